// File: rtl/inc_share_arbiter_pkg.sv
// Shared types and default widths for the shared +1 unit arbiter.
package inc_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 4;

endpackage

// File: rtl/inc_share_arbiter_inc_cla_w.sv
// Combinational W-bit carry-lookahead incrementer: every carry is a flat AND of lower bits.
module inc_cla_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] in,
  output logic [W-1:0] out,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = 1'b1;
  for (genvar j = 1; j <= W; j++) begin : g_carry
    assign c[j] = &in[j-1:0];
  end

  assign out  = in ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/inc_share_arbiter.sv
// Round-robin arbiter sharing one +1 unit among NREQ requesters; IDLE -> EXEC -> DONE.
module inc_share_arbiter
  import inc_share_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opnd,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [W-1:0]      result,
  output logic              cout
);

  state_t state, nstate;

  logic [NREQ-1:0][W-1:0] opnd_a;
  logic [W-1:0]           op_q;
  logic [IDW-1:0]         id_q;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         sel_id;
  logic                   sel_vld;
  logic [W-1:0]           inc_out;
  logic                   inc_cout;

  assign opnd_a = opnd;

  // First set request at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!sel_vld && req[idx]) begin
        sel_vld = 1'b1;
        sel_id  = IDW'(idx);
      end
    end
  end

  inc_cla_w #(.W(W)) u_inc (
    .in   (op_q),
    .out  (inc_out),
    .cout (inc_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (sel_vld) nstate = ST_EXEC;
      ST_EXEC: nstate = ST_DONE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt  = '0;
    busy = (state != ST_IDLE);
    if (state == ST_EXEC) gnt[id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      id_q    <= '0;
      rr_ptr  <= '0;
      result  <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (sel_vld) begin
          op_q <= opnd_a[sel_id];
          id_q <= sel_id;
        end
        ST_EXEC: begin
          result  <= inc_out;
          cout    <= inc_cout;
          done_id <= id_q;
          done    <= 1'b1;
          rr_ptr  <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
